// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexes one shared QIF update datapath across N_NEURONS virtual neurons.
// Each tick sweeps every neuron in index order and reports the resulting spike vector.
module qif_neuron_scheduler #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned IDXW      = 2,
  parameter logic [7:0]  V_TH      = 8'd200,
  parameter logic [7:0]  V_RESET   = 8'd0,
  parameter logic [7:0]  V_REST    = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic                 cfg_we,
  input  logic [IDXW-1:0]      cfg_addr,
  input  logic [7:0]           cfg_bias,
  output logic                 dp_req,
  output logic [7:0]           dp_v,
  output logic [7:0]           dp_b,
  input  logic                 dp_ack,
  input  logic [7:0]           dp_v_next,
  output logic [N_NEURONS-1:0] spike_o,
  output logic                 spike_valid,
  output logic                 busy,
  output logic                 overrun,
  input  logic [IDXW-1:0]      v_mon_sel,
  output logic [7:0]           v_mon
);

  typedef enum logic [1:0] {StIdle, StReq, StNext, StDone} state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d, idx_inc;
  logic [N_NEURONS-1:0] acc_q, acc_d, spike_q, spike_d;
  logic [7:0]           v_q [N_NEURONS];
  logic [7:0]           v_d [N_NEURONS];
  logic [7:0]           b_q [N_NEURONS];
  logic [7:0]           b_d [N_NEURONS];
  logic                 dp_req_q, dp_req_d;
  logic [7:0]           dp_v_q, dp_v_d, dp_b_q, dp_b_d;
  logic                 spike_valid_q, spike_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           v_mon_q, v_mon_d;
  logic                 hit;
  logic                 last;

  assign idx_inc = idx_q + 1'b1;
  assign hit     = (dp_v_next >= V_TH);
  assign last    = (32'(idx_q) == N_NEURONS - 1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    spike_d       = spike_q;
    v_d           = v_q;
    b_d           = b_q;
    dp_req_d      = dp_req_q;
    dp_v_d        = dp_v_q;
    dp_b_d        = dp_b_q;
    spike_valid_d = 1'b0;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    v_mon_d       = (32'(v_mon_sel) < N_NEURONS) ? v_q[v_mon_sel] : 8'd0;

    // Bias writes land in any state; operands already latched are untouched.
    if (cfg_we && (32'(cfg_addr) < N_NEURONS)) begin
      b_d[cfg_addr] = cfg_bias;
    end

    if (tick_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick_i) begin
          state_d  = StReq;
          idx_d    = '0;
          acc_d    = '0;
          dp_v_d   = v_q[0];
          dp_b_d   = b_q[0];
          dp_req_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      StReq: begin
        if (dp_ack) begin
          dp_req_d = 1'b0;
          if (hit) begin
            v_d[idx_q]   = V_RESET;
            acc_d[idx_q] = 1'b1;
          end else begin
            v_d[idx_q] = dp_v_next;
          end
          if (last) begin
            state_d       = StDone;
            spike_d       = acc_d;
            spike_valid_d = 1'b1;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        idx_d    = idx_inc;
        dp_v_d   = v_q[idx_inc];
        dp_b_d   = b_q[idx_inc];
        dp_req_d = 1'b1;
        state_d  = StReq;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      acc_q         <= '0;
      spike_q       <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        v_q[i] <= V_REST;
        b_q[i] <= 8'd0;
      end
      dp_req_q      <= 1'b0;
      dp_v_q        <= 8'd0;
      dp_b_q        <= 8'd0;
      spike_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      v_mon_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      spike_q       <= spike_d;
      v_q           <= v_d;
      b_q           <= b_d;
      dp_req_q      <= dp_req_d;
      dp_v_q        <= dp_v_d;
      dp_b_q        <= dp_b_d;
      spike_valid_q <= spike_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      v_mon_q       <= v_mon_d;
    end
  end

  assign dp_req      = dp_req_q;
  assign dp_v        = dp_v_q;
  assign dp_b        = dp_b_q;
  assign spike_o     = spike_q;
  assign spike_valid = spike_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign v_mon       = v_mon_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Directed and randomized sweeps of qif_neuron_scheduler against an arithmetic neuron model.
module tb_qif_neuron_scheduler;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick_i = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [7:0]   cfg_bias = '0;
  logic         dp_req;
  logic [7:0]   dp_v, dp_b;
  logic         dp_ack = 1'b0;
  logic [7:0]   dp_v_next = '0;
  logic [N-1:0] spike_o;
  logic         spike_valid, busy, overrun;
  logic [1:0]   v_mon_sel = '0;
  logic [7:0]   v_mon;

  int checks = 0;
  int errors = 0;
  int vm [N];
  int bm [N];
  int last_sp = 0;

  always #5 clk = ~clk;

  qif_neuron_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_bias   (cfg_bias),
    .dp_req     (dp_req),
    .dp_v       (dp_v),
    .dp_b       (dp_b),
    .dp_ack     (dp_ack),
    .dp_v_next  (dp_v_next),
    .spike_o    (spike_o),
    .spike_valid(spike_valid),
    .busy       (busy),
    .overrun    (overrun),
    .v_mon_sel  (v_mon_sel),
    .v_mon      (v_mon)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      vm[i] = 0;
      bm[i] = 0;
    end
    last_sp = 0;
  endtask

  task automatic write_bias(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = a[1:0];
    cfg_bias = v[7:0];
    cyc();
    cfg_we = 1'b0;
    bm[a] = v;
  endtask

  task automatic check_mon(input string tag);
    for (int i = 0; i < N; i++) begin
      v_mon_sel = i[1:0];
      cyc();
      check(tag, v_mon, vm[i]);
    end
  endtask

  // One sweep driven by a datapath computing v+b mod 256, acked w cycles after entry to REQ.
  task automatic do_sweep(input int w, input bit mid_tick, input bit mid_cfg, input int cfg_val);
    int exp_sp;
    int cycles;
    int nxt;
    exp_sp = 0;
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    cycles = 1;
    for (int k = 0; k < N; k++) begin
      check("req_hi", dp_req, 1);
      check("busy_sweep", busy, 1);
      check("dp_v", dp_v, vm[k]);
      check("dp_b", dp_b, bm[k]);
      for (int j = 0; j < w; j++) begin
        if (mid_cfg && k == 1 && j == 0) begin
          cfg_we   = 1'b1;
          cfg_addr = 2'd1;
          cfg_bias = cfg_val[7:0];
        end
        if (mid_tick && k == 1 && j == 0) tick_i = 1'b1;
        cyc();
        cycles++;
        cfg_we = 1'b0;
        tick_i = 1'b0;
        check("req_hold", dp_req, 1);
        check("dp_v_hold", dp_v, vm[k]);
        check("dp_b_hold", dp_b, bm[k]);
      end
      nxt = (vm[k] + bm[k]) % 256;
      if (mid_cfg && k == 1) bm[1] = cfg_val;
      dp_ack    = 1'b1;
      dp_v_next = nxt[7:0];
      cyc();
      cycles++;
      dp_ack    = 1'b0;
      dp_v_next = 8'($urandom);
      if (nxt >= 200) begin
        vm[k] = 0;
        exp_sp |= (1 << k);
      end else begin
        vm[k] = nxt;
      end
      if (k < N - 1) begin
        check("req_gap", dp_req, 0);
        cyc();
        cycles++;
      end
    end
    check("spike_valid", spike_valid, 1);
    check("spike_o", spike_o, exp_sp);
    check("latency", cycles, 2 * N + N * w);
    cyc();
    check("spike_valid_pulse", spike_valid, 0);
    check("busy_end", busy, 0);
    check("req_idle", dp_req, 0);
    last_sp = exp_sp;
  endtask

  initial begin
    // Reset with a tick held during reset.
    rst_n  = 1'b0;
    tick_i = 1'b1;
    cyc();
    cyc();
    check("rst_req", dp_req, 0);
    check("rst_busy", busy, 0);
    check("rst_spike", spike_o, 0);
    check("rst_dpv", dp_v, 0);
    check("rst_dpb", dp_b, 0);
    tick_i = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_req", dp_req, 0);
      check("idle_busy", busy, 0);
      check("idle_ovr", overrun, 0);
    end
    check_mon("rst_vmon");

    // Basic sweep.
    write_bias(0, 10);
    write_bias(1, 20);
    write_bias(2, 30);
    write_bias(3, 40);
    do_sweep(0, 1'b0, 1'b0, 0);
    check_mon("sweep_vmon");
    check("sweep_sp", spike_o, 0);

    // Threshold crossing.
    do_reset();
    write_bias(2, 120);
    do_sweep(0, 1'b0, 1'b0, 0);
    check("thr_v1", vm[2], 120);
    do_sweep(0, 1'b0, 1'b0, 0);
    check("thr_sp2", spike_o, 4'b0100);
    check_mon("thr_vmon2");
    do_sweep(0, 1'b0, 1'b0, 0);
    check("thr_sp3", spike_o, 0);
    check_mon("thr_vmon3");

    // Boundary: exactly 200 spikes, 199 does not.
    do_reset();
    write_bias(0, 200);
    write_bias(1, 199);
    do_sweep(0, 1'b0, 1'b0, 0);
    check("bound_sp", spike_o, 4'b0001);
    check_mon("bound_vmon");

    // Wait states.
    do_sweep(3, 1'b0, 1'b0, 0);
    check_mon("wait_vmon");

    // Overrun and mid-sweep bias write.
    do_sweep(2, 1'b1, 1'b1, 77);
    check("ovr_set", overrun, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("no_second_req", dp_req, 0);
      check("no_second_busy", busy, 0);
      check("spike_hold", spike_o, last_sp);
    end
    // Ack pulses outside REQ must not touch membrane state.
    dp_ack    = 1'b1;
    dp_v_next = 8'd99;
    cyc();
    cyc();
    dp_ack = 1'b0;
    check_mon("idle_ack_vmon");
    do_sweep(1, 1'b0, 1'b0, 0);
    check("ovr_sticky", overrun, 1);

    // Reset mid-sweep while idx 2 is requesting.
    write_bias(0, 5);
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dp_ack = 1'b1;
      cyc();
      dp_ack = 1'b0;
      cyc();
    end
    check("mid_req", dp_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_req", dp_req, 0);
    check("async_busy", busy, 0);
    check("async_ovr", overrun, 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      vm[i] = 0;
      bm[i] = 0;
    end
    check_mon("mid_rst_vmon");
    write_bias(0, 33);
    write_bias(3, 210);
    do_sweep(0, 1'b0, 1'b0, 0);
    check("post_rst_sp", spike_o, 4'b1000);

    // Randomized sweeps.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) write_bias(i, int'($urandom_range(0, 255)));
      end
      do_sweep(int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);
      check_mon("rand_vmon");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
